// File: rtl/calc_pkg.sv
// calc_pkg: operation encodings shared by the adder/subtractor datapath
package calc_pkg;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/cla_group.sv
// cla_group: G-bit carry-lookahead slice with flattened carries
module cla_group #(
    parameter int G = 4
) (
    input  logic [G-1:0] a,
    input  logic [G-1:0] b,
    input  logic         c_in,
    output logic [G-1:0] s,
    output logic         c_out,
    output logic         c_msb_in
);
    logic [G-1:0] g;
    logic [G-1:0] p;
    logic [G:0]   c;
    assign g = a & b;
    assign p = a ^ b;
    // every carry is a two-level sum of products over g, p and c_in
    always_comb begin : carries
        logic acc;
        logic pp;
        c = '0;
        for (int i = 0; i <= G; i++) begin
            acc = 1'b0;
            pp  = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (g[j] & pp);
                pp  = pp & p[j];
            end
            c[i] = acc | (c_in & pp);
        end
    end
    assign s        = p ^ c[G-1:0];
    assign c_out    = c[G];
    assign c_msb_in = c[G-1];
endmodule

// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub: skewed K-stage carry-lookahead adder/subtractor with valid/ready flow
module pipelined_cla_addsub
    import calc_pkg::*;
#(
    parameter int N = 16,
    parameter int G = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         cin,
    input  logic         op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Sum,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);
    localparam int K = N / G;
    logic stall;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    genvar k;
    for (k = 0; k <= K; k++) begin : stg
        logic         v_q, v_d;
        logic         c_q, c_d;
        logic         m_q, m_d;
        logic [N-1:0] a_q, a_d;
        logic [N-1:0] b_q, b_d;
        logic [N-1:0] s_q, s_d;
        logic         unused_bits;
        assign unused_bits = ^{a_q, b_q, m_q};
        if (k == 0) begin : g_in
            // capture the beat with B already conditioned for subtraction
            always_comb begin
                v_d = in_valid;
                a_d = A;
                b_d = (op == OP_SUB) ? ~B : B;
                c_d = (op == OP_SUB) ? 1'b1 : cin;
                s_d = '0;
                m_d = 1'b0;
            end
        end else begin : g_grp
            logic [G-1:0] gs;
            logic         gc;
            logic         gm;
            cla_group #(.G(G)) u_grp (
                .a        (stg[k-1].a_q[(k-1)*G +: G]),
                .b        (stg[k-1].b_q[(k-1)*G +: G]),
                .c_in     (stg[k-1].c_q),
                .s        (gs),
                .c_out    (gc),
                .c_msb_in (gm)
            );
            // resolve group k-1 and forward the rest of the beat alongside it
            always_comb begin
                v_d = stg[k-1].v_q;
                a_d = stg[k-1].a_q;
                b_d = stg[k-1].b_q;
                s_d = stg[k-1].s_q;
                s_d[(k-1)*G +: G] = gs;
                c_d = gc;
                m_d = gm;
            end
        end
        // stage register: cleared by reset, frozen while the output is stalled
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                m_q <= 1'b0;
                a_q <= '0;
                b_q <= '0;
                s_q <= '0;
            end else if (!stall) begin
                v_q <= v_d;
                c_q <= c_d;
                m_q <= m_d;
                a_q <= a_d;
                b_q <= b_d;
                s_q <= s_d;
            end
        end
    end
    assign out_valid = stg[K].v_q;
    assign Sum       = stg[K].s_q;
    assign cout      = stg[K].c_q;
    assign ovf       = stg[K].c_q ^ stg[K].m_q;
    assign zero      = ~|stg[K].s_q;
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb_pipelined_cla_addsub: directed and randomised checks of the pipelined adder/subtractor
module tb_pipelined_cla_addsub;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        cin;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          n_chk = 0;
    int          n_fail = 0;

    pipelined_cla_addsub #(.N(16), .G(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .cin       (cin),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string tag, input logic o, input logic [15:0] a, input logic [15:0] b,
                           input logic ci, input logic [15:0] es, input logic ec, input logic eo,
                           input logic ez);
        int n;
        op = o;
        A = a;
        B = b;
        cin = ci;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!out_valid && n < 20);
        check({tag, " latency"}, n, 4);
        check({tag, " sum"}, Sum, es);
        check({tag, " cout/ovf/zero"}, {cout, ovf, zero}, {ec, eo, ez});
        tick();
    endtask

    function automatic logic [15:0] pick();
        case ($urandom % 5)
            0: pick = 16'h0000;
            1: pick = 16'hFFFF;
            2: pick = 16'h8000;
            3: pick = 16'h7FFF;
            default: pick = 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [15:0] stall_exp [5];
        logic [17:0] q [$];
        logic [17:0] exp_r;
        logic [15:0] ra, rb, bb;
        logic [16:0] wide;
        logic        ro, rc, acc, xfer;
        int          vcnt, sent, got, cyc;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        A = '0;
        B = '0;
        cin = 1'b0;
        op = 1'b0;
        tick();
        tick();
        check("reset out_valid", out_valid, 0);
        check("reset sum", Sum, 0);
        check("reset cout/ovf/zero", {cout, ovf, zero}, 3'b001);
        rst_n = 1'b1;
        check("reset in_ready", in_ready, 1);

        run_one("add_00ff_1",   1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        run_one("sub_8000_1",   1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        run_one("sub_5_5",      1'b1, 16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_one("sub_5_5_cin",  1'b1, 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_one("add_wrap",     1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_one("add_7fff_1",   1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_one("add_cin",      1'b0, 16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0, 1'b0, 1'b0);
        run_one("sub_borrow",   1'b1, 16'h0001, 16'h0002, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        run_one("add_8000x2",   1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);

        op = 1'b0;
        cin = 1'b0;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c < 4);
            A = 16'(c + 1);
            B = 16'(c + 1);
            tick();
            if (c >= 3 && c <= 8) begin
                check($sformatf("b2b valid c%0d", c), out_valid, (c >= 4 && c <= 7));
                if (c >= 4 && c <= 7)
                    check($sformatf("b2b sum c%0d", c), Sum, 16'(2 * (c - 3)));
            end
        end

        stall_exp = '{16'h0101, 16'h1212, 16'h2323, 16'h3434, 16'h4545};
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall fill ready %0d", i), in_ready, 1);
            in_valid = 1'b1;
            A = 16'(i * 16'h1111);
            B = 16'h0101;
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall in_ready %0d", i), in_ready, 0);
            check($sformatf("stall hold %0d", i), {out_valid, Sum}, {1'b1, stall_exp[0]});
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("drain %0d", i), {out_valid, Sum}, {1'b1, stall_exp[i]});
            tick();
        end
        check("drain empty", out_valid, 0);

        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            A = 16'(i + 16'h0100);
            B = 16'h0001;
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst out_valid", out_valid, 0);
        check("midrst zero", zero, 1);
        check("midrst in_ready", in_ready, 1);
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            vcnt += int'(out_valid);
        end
        check("midrst no ghosts", vcnt, 0);

        sent = 0;
        got = 0;
        cyc = 0;
        while (got < 10000 && cyc < 60000) begin
            if (sent < 10000 && ($urandom % 4) != 0) begin
                ra = pick();
                rb = pick();
                ro = 1'($urandom);
                rc = 1'($urandom);
                in_valid = 1'b1;
                A = ra;
                B = rb;
                op = ro;
                cin = rc;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom % 4) != 0;
            @(negedge clk);
            acc = in_valid && in_ready;
            xfer = out_valid && out_ready;
            if (xfer) begin
                exp_r = (q.size() > 0) ? q.pop_front() : 18'h3FFFF;
                check("random beat", {cout, ovf, Sum}, exp_r);
                got++;
            end
            if (acc) begin
                bb = op ? ~B : B;
                wide = {1'b0, A} + {1'b0, bb} + 17'(op ? 1'b1 : cin);
                q.push_back({wide[16], (A[15] == bb[15]) && (wide[15] != A[15]), wide[15:0]});
                sent++;
            end
            tick();
            cyc++;
        end
        check("random completed", got, 10000);
        in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pipelined_cla_addsub.md
PIPELINED_CLA_ADDSUB -- requirements
Module: pipelined_cla_addsub

Interface
REQ-001 Parameter N, default 16, operand/result width in bits.
REQ-002 Parameter G, default 4, carry-lookahead group width in bits; N SHALL be an integer multiple of G, and K = N/G SHALL be at least 2.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block can accept a beat this cycle.
REQ-007 A  input  N  operand A, unsigned or two's complement.
REQ-008 B  input  N  operand B.
REQ-009 cin  input  1  carry in, used for ADD only.
REQ-010 op  input  1  0 = ADD (A+B+cin), 1 = SUB (A-B).
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  downstream accepts the result beat.
REQ-013 Sum  output  N  result.
REQ-014 cout  output  1  carry out of bit N-1; for SUB, 1 means no borrow.
REQ-015 ovf  output  1  signed overflow.
REQ-016 zero  output  1  Sum equals 0.

Function
REQ-017 A beat SHALL transfer on a cycle where in_valid and in_ready are both 1. A result SHALL transfer on a cycle where out_valid and out_ready are both 1.
REQ-018 SUB SHALL be computed as A + ~B + 1; cin SHALL be ignored when op=1.
REQ-019 The datapath SHALL be a K-stage pipeline; stage k resolves bits [kG+G-1:kG] with a G-bit lookahead group.
REQ-020 Each group SHALL compute its carry internally from generate/propagate terms, with no ripple inside the group; the only inter-group carry SHALL be the registered carry from stage k-1.
REQ-021 Operand bits not yet consumed, together with the sum bits already produced, SHALL travel with the beat in each stage's registers (skew/deskew), so the Sum bits of one beat leave together.
REQ-022 Latency SHALL be exactly K cycles from the accepting edge to out_valid=1 when there are no stalls; throughput SHALL be one beat per cycle.
REQ-023 Stall SHALL equal out_valid AND NOT out_ready. While stall is 1, every stage register SHALL hold its value and in_ready SHALL be 0.
REQ-024 in_ready SHALL equal NOT stall; it is combinational from out_ready, with no other combinational path from input to output.
REQ-025 Each stage SHALL carry a valid bit; bubbles SHALL propagate, and out_valid SHALL be the valid bit of the last stage.
REQ-026 cout SHALL be the carry out of group K-1.
REQ-027 ovf SHALL equal the carry into bit N-1 XOR the carry out of bit N-1.
REQ-028 zero SHALL be the NOR of all N bits of Sum, taken from the registered output.
REQ-029 Sum, cout, ovf and zero SHALL be stable while out_valid=1 and out_ready=0.
REQ-030 Simultaneous accept and output transfer in the same cycle SHALL lose no beat and SHALL duplicate no beat.
REQ-031 Carry wrap-around is not retained: A=all-ones, B=1, ADD SHALL give Sum=0, cout=1 and zero=1.

Reset
REQ-032 When rst_n=0 at a clock edge, every stage valid bit SHALL clear, and out_valid=0, Sum=0, cout=0, ovf=0 and zero=1 SHALL hold after that edge.
REQ-033 A reset asserted mid-operation SHALL discard all in-flight beats, and none of them SHALL appear after reset.
REQ-034 in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-035 A shared package calc_pkg SHALL hold the op encoding constants OP_ADD=0 and OP_SUB=1.
REQ-036 One sub-module cla_group, parametrised by G, SHALL be instantiated K times.
  - cla_group is combinational.
  - Inputs: a, b, c_in.
  - Outputs: s, c_out, c_msb_in (carry into the group MSB, used for ovf).
REQ-037 The pipeline registers SHALL live in the top module, generated per stage.

Verification (N=16, G=4)
REQ-038 ADD A=0x00FF, B=0x0001, cin=0 -> Sum=0x0100, cout=0, ovf=0, zero=0, out_valid exactly 4 cycles after accept.
REQ-039 SUB A=0x8000, B=0x0001 -> Sum=0x7FFF, cout=1, ovf=1; SUB A=0x0005, B=0x0005 -> Sum=0, zero=1, cout=1.
REQ-040 Back-to-back beats 1+1, 2+2, 3+3, 4+4 with out_ready=1 -> results 2, 4, 6, 8 on 4 consecutive cycles, starting 4 cycles after the first accept.
REQ-041 Hold out_ready=0 for 5 cycles with the pipe full -> in_ready=0, outputs frozen, no loss or duplication once out_ready=1.
REQ-042 Assert rst_n=0 for 1 cycle with 3 beats in flight -> out_valid=0, zero=1, none of the 3 results ever appear.
REQ-043 Random constrained operands, op, cin and out_ready over 10k beats -> every Sum, cout and ovf matches a reference model, and results emerge in order.
